// File: rtl/master_hash_slave_hash_drbg_pkg.sv
// Shared constants for the two-level SHA-256 Hash-DRBG.
// Holds the SHA-256 round constants, the initial hash value and the sequencer state encoding.
package master_hash_slave_hash_drbg_pkg;

    localparam int DIGEST_W = 256;
    localparam int CNT_W    = 64;

    typedef enum logic [2:0] {
        IDLE,
        INST,
        REINST,
        SEED,
        RESEED,
        READY,
        GEN
    } drbg_state_e;

    localparam logic [31:0] SHA_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] SHA_H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/master_hash_slave_hash_drbg_if.sv
// Request/response bundle between the keystream consumer and the DRBG.
// The consumer uses the master modport; the DRBG uses the slave modport.
interface master_hash_slave_hash_drbg_if;
    import master_hash_slave_hash_drbg_pkg::*;

    logic                is_master_mode;
    logic                init;
    logic                next_seed;
    logic                next_bits;
    logic                catch_up_mode;
    logic [DIGEST_W-1:0] entropy;
    logic                init_ready;
    logic                next_bits_ready;
    logic [DIGEST_W-1:0] random_bits;
    logic [CNT_W-1:0]    reseed_counter;

    modport master (
        output is_master_mode, init, next_seed, next_bits, catch_up_mode, entropy,
        input  init_ready, next_bits_ready, random_bits, reseed_counter
    );

    modport slave (
        input  is_master_mode, init, next_seed, next_bits, catch_up_mode, entropy,
        output init_ready, next_bits_ready, random_bits, reseed_counter
    );

endinterface

// File: rtl/master_hash_slave_hash_drbg_sha256_single_block.sv
// Iterative SHA-256 of a 32-byte message: one load cycle, 64 round cycles, one finalize cycle.
// The message schedule is a 16-word sliding window, so only W[t..t+15] is ever stored.
module sha256_single_block
    import master_hash_slave_hash_drbg_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] msg,
    output logic [255:0] digest,
    output logic         done
);

    logic [31:0] st [8];
    logic [31:0] w  [16];
    logic [5:0]  rnd;
    logic        busy;
    logic        fin;
    logic        load;
    logic        step;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] w_next;

    always_comb begin
        load   = start && !busy;
        step   = busy && !fin;
        t1     = st[7] + big_sigma1(st[4]) + ((st[4] & st[5]) ^ (~st[4] & st[6])) + SHA_K[rnd] + w[0];
        t2     = big_sigma0(st[0]) + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
        w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            fin  <= 1'b0;
            done <= 1'b0;
            rnd  <= '0;
        end else begin
            done <= fin;
            if (load) begin
                busy <= 1'b1;
                rnd  <= '0;
            end else if (step) begin
                rnd <= rnd + 6'd1;
                if (rnd == 6'd63) fin <= 1'b1;
            end else if (fin) begin
                fin  <= 1'b0;
                busy <= 1'b0;
            end
        end
    end

    // Padding is fixed for a 256-bit message: 0x80 marker, zeros, length 0x100.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 8; i++) begin
                st[i] <= SHA_H0[255-32*i -: 32];
                w[i]  <= msg[255-32*i -: 32];
            end
            w[8] <= 32'h8000_0000;
            for (int i = 9; i < 15; i++) w[i] <= 32'h0;
            w[15] <= 32'h0000_0100;
        end else if (step) begin
            st[7] <= st[6];
            st[6] <= st[5];
            st[5] <= st[4];
            st[4] <= st[3] + t1;
            st[3] <= st[2];
            st[2] <= st[1];
            st[1] <= st[0];
            st[0] <= t1 + t2;
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_next;
        end
        if (fin) begin
            for (int i = 0; i < 8; i++) digest[255-32*i -: 32] <= st[i] + SHA_H0[255-32*i -: 32];
        end
    end

endmodule

// File: rtl/master_hash_slave_hash_drbg.sv
// Two-level Hash-DRBG: a master DRBG derives seeds for a slave DRBG that emits 256-bit words.
// One shared SHA-256 core is time-multiplexed between H(entropy), H(Vm), H(seed) and H(Vs).
module master_hash_slave_hash_drbg
    import master_hash_slave_hash_drbg_pkg::*;
#(
    parameter int BITS_GENERATOR_MAX_CYCLE = 128,
    parameter int SEED_GENERATOR_MAX_CYCLE = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    master_hash_slave_hash_drbg_if.slave  drbg
);

    localparam logic [CNT_W-1:0] BITS_MAX = CNT_W'(BITS_GENERATOR_MAX_CYCLE);
    localparam logic [CNT_W-1:0] SEED_MAX = CNT_W'(SEED_GENERATOR_MAX_CYCLE);

    drbg_state_e         state;
    logic                issued;
    logic                sha_start;
    logic [DIGEST_W-1:0] sha_msg;
    logic [DIGEST_W-1:0] sha_digest;
    logic                sha_done;
    logic [DIGEST_W-1:0] v_m;
    logic [DIGEST_W-1:0] v_s;
    logic [DIGEST_W-1:0] seed_q;
    logic [CNT_W-1:0]    ms_cnt;
    logic [CNT_W-1:0]    gen_cnt;
    logic [DIGEST_W-1:0] random_bits_q;
    logic                init_ready_q;
    logic                next_bits_ready_q;
    logic [CNT_W-1:0]    reseed_counter_q;

    sha256_single_block u_sha (
        .clk    (clk),
        .rst    (reset),
        .start  (sha_start),
        .msg    (sha_msg),
        .digest (sha_digest),
        .done   (sha_done)
    );

    assign drbg.init_ready      = init_ready_q;
    assign drbg.next_bits_ready = next_bits_ready_q;
    assign drbg.random_bits     = random_bits_q;
    assign drbg.reseed_counter  = reseed_counter_q;

    // Each hashing state fires the core once (issued=0), then waits for done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            issued            <= 1'b0;
            sha_start         <= 1'b0;
            v_m               <= '0;
            v_s               <= '0;
            seed_q            <= '0;
            ms_cnt            <= '0;
            gen_cnt           <= '0;
            random_bits_q     <= '0;
            init_ready_q      <= 1'b0;
            next_bits_ready_q <= 1'b0;
            reseed_counter_q  <= '0;
        end else begin
            sha_start         <= 1'b0;
            next_bits_ready_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (drbg.init) begin
                        reseed_counter_q <= '0;
                        state            <= INST;
                    end
                end
                INST: begin
                    if (!issued) begin
                        sha_start <= 1'b1;
                        sha_msg   <= drbg.entropy;
                        issued    <= 1'b1;
                    end else if (sha_done) begin
                        v_m    <= sha_digest;
                        ms_cnt <= '0;
                        issued <= 1'b0;
                        state  <= SEED;
                    end
                end
                REINST: begin
                    if (!issued) begin
                        sha_start <= 1'b1;
                        sha_msg   <= v_m ^ drbg.entropy;
                        issued    <= 1'b1;
                    end else if (sha_done) begin
                        v_m    <= sha_digest;
                        ms_cnt <= '0;
                        issued <= 1'b0;
                        state  <= SEED;
                    end
                end
                SEED: begin
                    if (!drbg.is_master_mode) begin
                        seed_q <= drbg.entropy;
                        state  <= RESEED;
                    end else if (!issued) begin
                        sha_start <= 1'b1;
                        sha_msg   <= v_m;
                        issued    <= 1'b1;
                    end else if (sha_done) begin
                        seed_q <= sha_digest;
                        v_m    <= v_m + sha_digest + DIGEST_W'(ms_cnt) + DIGEST_W'(1);
                        ms_cnt <= ms_cnt + 64'd1;
                        issued <= 1'b0;
                        state  <= RESEED;
                    end
                end
                RESEED: begin
                    if (!issued) begin
                        sha_start <= 1'b1;
                        sha_msg   <= seed_q;
                        issued    <= 1'b1;
                    end else if (sha_done) begin
                        v_s              <= sha_digest;
                        gen_cnt          <= '0;
                        reseed_counter_q <= reseed_counter_q + 64'd1;
                        init_ready_q     <= 1'b1;
                        issued           <= 1'b0;
                        state            <= READY;
                    end
                end
                READY: begin
                    // >= keeps re-instantiation reachable after extra next_seed reseeds.
                    if (gen_cnt >= BITS_MAX) begin
                        init_ready_q <= 1'b0;
                        state <= (drbg.is_master_mode && ms_cnt >= SEED_MAX) ? REINST : SEED;
                    end else if (drbg.next_seed) begin
                        init_ready_q <= 1'b0;
                        state        <= SEED;
                    end else if (drbg.next_bits || drbg.catch_up_mode) begin
                        state <= GEN;
                    end
                end
                GEN: begin
                    if (!issued) begin
                        sha_start <= 1'b1;
                        sha_msg   <= v_s;
                        issued    <= 1'b1;
                    end else if (sha_done) begin
                        random_bits_q     <= sha_digest;
                        v_s               <= v_s + sha_digest + DIGEST_W'(gen_cnt) + DIGEST_W'(1);
                        gen_cnt           <= gen_cnt + 64'd1;
                        next_bits_ready_q <= 1'b1;
                        issued            <= 1'b0;
                        state             <= READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_master_hash_slave_hash_drbg.sv
// Directed bench for the two-level Hash-DRBG with a small independent SHA-256/DRBG reference model.
// Generator limits are shrunk so exhaustion and re-instantiation occur within a short run.
`timescale 1ns/1ps
module tb_master_hash_slave_hash_drbg;

    localparam int BITS  = 4;
    localparam int SEEDS = 1;

    localparam logic [31:0] TK [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] TH [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    master_hash_slave_hash_drbg_if dif ();

    master_hash_slave_hash_drbg #(
        .BITS_GENERATOR_MAX_CYCLE (BITS),
        .SEED_GENERATOR_MAX_CYCLE (SEEDS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .drbg  (dif.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [255:0] m_vm, m_vs, m_sd;
    logic [63:0]  m_ms, m_gen;
    logic [255:0] first_seed;
    logic [255:0] mstream [BITS];

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_ref(input logic [255:0] m);
        logic [511:0] blk;
        logic [31:0]  w [64];
        logic [31:0]  s [8];
        logic [31:0]  x1, x2;
        logic [255:0] r;
        blk = {m, 8'h80, 184'd0, 64'd256};
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = blk[511-32*t -: 32];
            else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        for (int i = 0; i < 8; i++) s[i] = TH[i];
        for (int t = 0; t < 64; t++) begin
            x1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + TK[t] + w[t];
            x2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            for (int i = 7; i > 0; i--) s[i] = s[i-1];
            s[4] = s[4] + x1;
            s[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = TH[i] + s[i];
        return r;
    endfunction

    task automatic m_seed(input logic [255:0] ent, input bit master);
        if (master) begin
            m_sd = sha_ref(m_vm);
            m_vm = m_vm + m_sd + {192'd0, m_ms} + 256'd1;
            m_ms = m_ms + 64'd1;
        end else begin
            m_sd = ent;
        end
        m_vs  = sha_ref(m_sd);
        m_gen = 64'd0;
    endtask

    task automatic m_init(input logic [255:0] ent, input bit master);
        m_vm = sha_ref(ent);
        m_ms = 64'd0;
        m_seed(ent, master);
    endtask

    task automatic m_word(input logic [255:0] ent, input bit master, output logic [255:0] w);
        if (m_gen == 64'(BITS)) begin
            if (master && m_ms == 64'(SEEDS)) begin
                m_vm = sha_ref(m_vm ^ ent);
                m_ms = 64'd0;
            end
            m_seed(ent, master);
        end
        w     = sha_ref(m_vs);
        m_vs  = m_vs + w + {192'd0, m_gen} + 256'd1;
        m_gen = m_gen + 64'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int budget, output bit ok, output int lat);
        ok = 1'b0;
        lat = 0;
        while (!ok && lat < budget) begin
            tick();
            lat++;
            if (dif.next_bits_ready === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_ready(input logic lvl, input int budget, output bit ok, output int lat);
        ok = 1'b0;
        lat = 0;
        while (!ok && lat < budget) begin
            tick();
            lat++;
            if (dif.init_ready === lvl) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dif.init = 1'b0;
        dif.next_bits = 1'b0;
        dif.next_seed = 1'b0;
        dif.catch_up_mode = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    // next_bits_ready must never be high on two consecutive cycles
    logic prev_nbr = 1'b0;
    always @(negedge clk) begin
        if (dif.next_bits_ready === 1'b1) begin
            n_cmp++;
            if (prev_nbr) begin
                n_bad++;
                $display("FAIL pulse_consecutive got=1 want=0 at %0t", $time);
            end
        end
        prev_nbr = (dif.next_bits_ready === 1'b1);
    end

    task automatic test_reset();
        dif.is_master_mode = 1'b1;
        dif.entropy = '0;
        do_reset();
        n_cmp++; if (dif.init_ready !== 1'b0) begin n_bad++; $display("FAIL reset_init_ready got=%b want=0", dif.init_ready); end
        n_cmp++; if (dif.next_bits_ready !== 1'b0) begin n_bad++; $display("FAIL reset_nbr got=%b want=0", dif.next_bits_ready); end
        n_cmp++; if (dif.random_bits !== 256'd0) begin n_bad++; $display("FAIL reset_random_bits got=%h want=0", dif.random_bits); end
        n_cmp++; if (dif.reseed_counter !== 64'd0) begin n_bad++; $display("FAIL reset_counter got=%0d want=0", dif.reseed_counter); end
    endtask

    task automatic test_model_kat();
        logic [255:0] h;
        h = sha_ref(256'd0);
        n_cmp++;
        if (h !== 256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925) begin
            n_bad++; $display("FAIL model_kat got=%h want=66687aad...2925", h);
        end
    endtask

    task automatic test_init_master();
        bit ok; int lat; logic [255:0] exp;
        m_init(256'd0, 1'b1);
        first_seed = m_sd;
        dif.is_master_mode = 1'b1;
        dif.entropy = '0;
        dif.init = 1'b1;
        tick();
        dif.init = 1'b0;
        wait_ready(1'b1, 209, ok, lat);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL init_latency got=timeout want<=210"); end
        n_cmp++; if (dif.reseed_counter !== 64'd1) begin n_bad++; $display("FAIL init_counter got=%0d want=1", dif.reseed_counter); end
        dif.next_bits = 1'b1;
        wait_pulse(70, ok, lat);
        dif.next_bits = 1'b0;
        m_word(256'd0, 1'b1, exp);
        mstream[0] = exp;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL word1_latency got=timeout want<=70"); end
        n_cmp++; if (dif.random_bits !== exp) begin n_bad++; $display("FAIL word1 got=%h want=%h", dif.random_bits, exp); end
    endtask

    task automatic test_back_to_back();
        bit ok; int lat; logic [255:0] exp;
        dif.next_bits = 1'b1;
        for (int i = 1; i < BITS; i++) begin
            wait_pulse(70, ok, lat);
            m_word(256'd0, 1'b1, exp);
            mstream[i] = exp;
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_latency[%0d] got=timeout want<=70", i); end
            n_cmp++; if (dif.random_bits !== exp) begin n_bad++; $display("FAIL b2b_word[%0d] got=%h want=%h", i, dif.random_bits, exp); end
        end
        wait_ready(1'b0, 5, ok, lat);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL exhaust_fall got=%b want=0", dif.init_ready); end
        wait_ready(1'b1, 210, ok, lat);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL exhaust_rise got=%b want=1", dif.init_ready); end
        n_cmp++; if (dif.reseed_counter !== 64'd2) begin n_bad++; $display("FAIL exhaust_counter got=%0d want=2", dif.reseed_counter); end
        wait_pulse(70, ok, lat);
        dif.next_bits = 1'b0;
        m_word(256'd0, 1'b1, exp);
        n_cmp++; if (!ok || dif.random_bits !== exp) begin n_bad++; $display("FAIL word_after_reseed got=%h want=%h", dif.random_bits, exp); end
    endtask

    task automatic test_slave_mode();
        bit ok; int lat;
        do_reset();
        dif.is_master_mode = 1'b0;
        dif.entropy = first_seed;
        dif.init = 1'b1;
        tick();
        dif.init = 1'b0;
        wait_ready(1'b1, 209, ok, lat);
        n_cmp++; if (!ok || dif.reseed_counter !== 64'd1) begin n_bad++; $display("FAIL slave_init got=%0d want=1", dif.reseed_counter); end
        dif.next_bits = 1'b1;
        for (int i = 0; i < BITS; i++) begin
            wait_pulse(70, ok, lat);
            n_cmp++; if (!ok || dif.random_bits !== mstream[i]) begin n_bad++; $display("FAIL slave_word[%0d] got=%h want=%h", i, dif.random_bits, mstream[i]); end
        end
        dif.next_bits = 1'b0;
    endtask

    task automatic test_next_seed();
        bit ok; int lat; logic [255:0] exp; logic [255:0] ent;
        ent = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
        do_reset();
        dif.is_master_mode = 1'b1;
        dif.entropy = ent;
        m_init(ent, 1'b1);
        dif.init = 1'b1;
        tick();
        dif.init = 1'b0;
        wait_ready(1'b1, 209, ok, lat);
        for (int i = 0; i < 3; i++) begin
            dif.next_bits = 1'b1;
            wait_pulse(70, ok, lat);
            dif.next_bits = 1'b0;
            m_word(ent, 1'b1, exp);
            n_cmp++; if (!ok || dif.random_bits !== exp) begin n_bad++; $display("FAIL ns_word[%0d] got=%h want=%h", i, dif.random_bits, exp); end
        end
        dif.next_seed = 1'b1;
        tick();
        dif.next_seed = 1'b0;
        n_cmp++; if (dif.init_ready !== 1'b0) begin n_bad++; $display("FAIL ns_fall got=%b want=0", dif.init_ready); end
        wait_ready(1'b1, 140, ok, lat);
        n_cmp++; if (!ok || dif.reseed_counter !== 64'd2) begin n_bad++; $display("FAIL ns_counter got=%0d want=2", dif.reseed_counter); end
        m_seed(ent, 1'b1);
        dif.next_bits = 1'b1;
        wait_pulse(70, ok, lat);
        dif.next_bits = 1'b0;
        m_word(ent, 1'b1, exp);
        n_cmp++; if (!ok || dif.random_bits !== exp) begin n_bad++; $display("FAIL ns_new_word got=%h want=%h", dif.random_bits, exp); end
    endtask

    task automatic test_catch_up();
        bit ok; int lat; logic [255:0] exp; logic [255:0] ent;
        ent = {8{32'hc0ffee11}};
        do_reset();
        dif.is_master_mode = 1'b1;
        dif.entropy = ent;
        m_init(ent, 1'b1);
        dif.init = 1'b1;
        tick();
        dif.init = 1'b0;
        wait_ready(1'b1, 209, ok, lat);
        dif.catch_up_mode = 1'b1;
        for (int i = 0; i < BITS + 1; i++) begin
            wait_pulse(300, ok, lat);
            m_word(ent, 1'b1, exp);
            n_cmp++; if (!ok || dif.random_bits !== exp) begin n_bad++; $display("FAIL catchup_word[%0d] got=%h want=%h", i, dif.random_bits, exp); end
        end
        dif.catch_up_mode = 1'b0;
        n_cmp++; if (dif.reseed_counter !== 64'd2) begin n_bad++; $display("FAIL catchup_counter got=%0d want=2", dif.reseed_counter); end
    endtask

    task automatic test_reset_mid_gen();
        bit ok; int lat;
        dif.next_bits = 1'b1;
        repeat (20) tick();
        reset = 1'b1;
        dif.next_bits = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (dif.random_bits !== 256'd0) begin n_bad++; $display("FAIL midreset_bits got=%h want=0", dif.random_bits); end
        n_cmp++; if (dif.init_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_init_ready got=%b want=0", dif.init_ready); end
        n_cmp++; if (dif.reseed_counter !== 64'd0) begin n_bad++; $display("FAIL midreset_counter got=%0d want=0", dif.reseed_counter); end
        wait_pulse(150, ok, lat);
        n_cmp++; if (ok) begin n_bad++; $display("FAIL midreset_pulse got=1 want=0 after %0d cycles", lat); end
    endtask

    initial begin
        dif.is_master_mode = 1'b1;
        dif.init = 1'b0;
        dif.next_seed = 1'b0;
        dif.next_bits = 1'b0;
        dif.catch_up_mode = 1'b0;
        dif.entropy = '0;
        test_reset();
        test_model_kat();
        test_init_master();
        test_back_to_back();
        test_slave_mode();
        test_next_seed();
        test_catch_up();
        test_reset_mid_gen();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/master_hash_slave_hash_drbg.md
Name: master_hash_slave_hash_drbg

Overview:
- Two-level SHA-256 Hash-DRBG keystream source for the video scrambler.
- A master DRBG, seeded from `entropy`, produces 256-bit seeds. A slave DRBG, seeded from those seeds, produces 256-bit `random_bits` words on request.
- Slave mode (descrambler side) bypasses the master and seeds the slave directly from `entropy`, so both ends produce identical streams.

Parameters:
- BITS_GENERATOR_MAX_CYCLE, 128: slave outputs per seed before an automatic slave reseed.
- SEED_GENERATOR_MAX_CYCLE, 8: master seeds per instantiation before the master re-instantiates from `entropy`.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- is_master_mode  in  1  1: seeds come from the master DRBG; 0: seeds come from `entropy`.
- init  in  1  level; start instantiation from IDLE.
- next_seed  in  1  level; force an early slave reseed when sampled in READY.
- next_bits  in  1  level; request one output word when sampled in READY.
- catch_up_mode  in  1  1: treat `next_bits` as permanently asserted.
- entropy  in  256  entropy (master mode) or external seed (slave mode); sampled at instantiate/reseed.
- init_ready  out  1  high while the slave is seeded and the block is idle in READY or generating.
- next_bits_ready  out  1  one-cycle pulse when `random_bits` updates.
- random_bits  out  256  last output word; held stable between pulses.
- reseed_counter  out  64  slave reseeds since the last init.

Behaviour:
- Definition of H(x): SHA-256 of the 32-byte message x, padded per FIPS 180-4. This is exactly one compression block: x, then 0x80, zeros, and length 0x100.
- All additions are mod 2^256.
- Reset:
  - state = IDLE.
  - Vm, Vs, random_bits = 0.
  - init_ready = 0, next_bits_ready = 0.
  - reseed_counter = 0; internal counters ms_cnt and gen_cnt = 0.
- Overall sequencing:
  - IDLE --init--> INST.
  - INST: Vm = H(entropy); ms_cnt = 0. Then go to SEED.
  - SEED:
    - Master mode: seed = H(Vm); Vm = Vm + seed + ms_cnt + 1; ms_cnt++.
    - Slave mode: seed = entropy.
    - Then go to RESEED.
  - RESEED: Vs = H(seed); gen_cnt = 0; reseed_counter++; init_ready = 1 on entry to READY.
  - READY:
    - `next_seed` → SEED.
    - Otherwise `next_bits`, or `catch_up_mode` = 1 → GEN.
    - `next_seed` takes priority over `next_bits`.
  - GEN:
    - out = H(Vs); Vs = Vs + out + gen_cnt + 1; gen_cnt++.
    - random_bits = out; pulse next_bits_ready for 1 cycle.
    - Return to READY.
- Exhaustion:
  - Detected in READY when gen_cnt == BITS_GENERATOR_MAX_CYCLE.
  - init_ready drops and the block goes to SEED automatically.
  - If ms_cnt == SEED_GENERATOR_MAX_CYCLE (master mode), it goes to REINST first: Vm = H(Vm ^ entropy), ms_cnt = 0, then SEED.
  - init_ready rises again at the next READY, so generation continues without a new init.
- init_ready is 0 in IDLE, INST, SEED, REINST and RESEED, and 1 in READY and GEN.
- `init` is ignored outside IDLE.
- reseed_counter is cleared on entry to INST and wraps at 2^64.
- Latency:
  - Each H() takes 65 cycles (1 load + 64 rounds) plus 1 cycle to finalize the digest.
  - Request to next_bits_ready pulse ≤ 70 cycles.
  - Init to init_ready ≤ 3·70 cycles.
- next_bits_ready is never asserted in two consecutive cycles.
- `next_bits` held high produces back-to-back words. A requester that drops `next_bits` after a pulse and raises it again gets exactly one word per pulse.
- Reset mid-hash aborts the hash: all state returns to reset values and no pulse is emitted.

Decomposition:
- Package drbg_pkg:
  - SHA-256 K constants and initial H0..H7.
  - FSM state enum {IDLE, INST, REINST, SEED, RESEED, READY, GEN}.
  - Width constants 256 and 64.
- One sub-module, sha256_single_block: iterative one-round-per-cycle compression of a padded 256-bit message.
  - Ports: start, msg[255:0], digest[255:0], done.
  - The top level time-multiplexes it among H(entropy), H(Vm), H(seed) and H(Vs).

Test Plan:
- Reset, then init=1 with entropy=0, master mode, SEED=1, BITS=1024 → init_ready rises with reseed_counter=1; first random_bits equals the software model H(H(H(H(0)))).
- Hold next_bits=1 → 1024 pulses, each with random_bits matching the model. init_ready then falls, rises again (reseed_counter=2), and pulse 1025 arrives.
- Slave mode, entropy = the seed value the master computed in the first scenario → random_bits sequence is bit-identical to the master-mode run.
- next_seed=1 in READY after 3 words → init_ready falls then rises; reseed_counter increments; the next word equals H of the new Vs.
- catch_up_mode=1, next_bits=0 → pulses continue; word N matches the model.
- Reset asserted during GEN → outputs return to 0 and no next_bits_ready pulse follows.
